inst_mem_loader: RTL and testbench

Writable instruction store for the pipelined CPU. A host feeds a byte stream over a valid/ready handshake. The block packs each group of four bytes into a 32-bit word and writes the words into a 64-entry instruction memory, starting at address 0. The CPU fetch stage reads the same memory through a combinational port. While a load is in progress, that port returns the nop encoding `32'h00000000` and a stall is raised.

---
 rtl/inst_mem_loader.sv | 122 ++++++++++++
 tb/tb_inst_mem_loader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_mem_loader                                                            |
// | Packs a host byte stream into 32-bit words and writes them into a          |
// | 64-entry instruction store read combinationally by the fetch stage.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_mem_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [6:0]        load_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              busy,
   output logic              cpu_stall,
   output logic              done,
   output logic [6:0]        words_loaded,
   input  logic [ADDR_W-1:0] a,
   output logic [31:0]       inst
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RECV  = 2'd1;
   localparam logic [1:0] c_WRITE = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [6:0]        c_MAX_CNT  = 7'(DEPTH);
   localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

   logic [1:0]        r_state;
   logic [6:0]        r_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [1:0]        r_byte_idx;
   logic [31:0]       r_word;
   logic [6:0]        r_words_loaded;
   logic [31:0]       r_mem [DEPTH];

   logic [6:0]        w_cnt_clamped;
   logic [6:0]        w_next_loaded;
   logic              w_busy;
   logic              w_write_en;

   assign w_cnt_clamped = (load_count > c_MAX_CNT) ? c_MAX_CNT : load_count;
   assign w_next_loaded = r_words_loaded + 7'd1;
   assign w_busy        = (r_state != c_IDLE);
   assign w_write_en    = (r_state == c_WRITE);

   assign byte_ready   = (r_state == c_RECV);
   assign busy         = w_busy;
   assign cpu_stall    = w_busy;
   assign done         = (r_state == c_DONE);
   assign words_loaded = r_words_loaded;

   // Fetch sees nops while the store is being rewritten.
   assign inst = w_busy ? 32'h0000_0000 : r_mem[a];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= c_IDLE;
         r_cnt          <= 7'd0;
         r_wr_addr      <= '0;
         r_byte_idx     <= 2'd0;
         r_word         <= 32'h0;
         r_words_loaded <= 7'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (load_start) begin
                  r_cnt          <= w_cnt_clamped;
                  r_wr_addr      <= '0;
                  r_byte_idx     <= 2'd0;
                  r_words_loaded <= 7'd0;
                  r_state        <= (w_cnt_clamped == 7'd0) ? c_DONE : c_RECV;
               end
            end
            c_RECV: begin
               if (byte_valid) begin
                  // Big-endian: earliest byte shifts up to [31:24].
                  r_word     <= {r_word[23:0], byte_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_state <= c_WRITE;
                  end
               end
            end
            c_WRITE: begin
               r_wr_addr      <= r_wr_addr + c_ADDR_ONE;
               r_words_loaded <= w_next_loaded;
               if (w_next_loaded == r_cnt) begin
                  r_state <= c_DONE;
               end else begin
                  r_state    <= c_RECV;
                  r_byte_idx <= 2'd0;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else if (w_write_en) begin
         r_mem[r_wr_addr] <= r_word;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_mem_loader                                                         |
// | Directed self-checking bench for inst_mem_loader.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic [6:0]  load_count = 7'd0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        busy;
   logic        cpu_stall;
   logic        done;
   logic [6:0]  words_loaded;
   logic [5:0]  a = 6'd0;
   logic [31:0] inst;

   int n_checks = 0;
   int n_pass   = 0;

   inst_mem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .load_count   (load_count),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .busy         (busy),
      .cpu_stall    (cpu_stall),
      .done         (done),
      .words_loaded (words_loaded),
      .a            (a),
      .inst         (inst)
   );

   always #5 clk = ~clk;

   // Advance one clock; sampling happens 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses load_start across edge t0; returns in cycle t1.
   task automatic start_load(input logic [6:0] cnt);
      load_start = 1'b1;
      load_count = cnt;
      step();
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      byte_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if ({busy, cpu_stall, byte_ready, done} !== 4'b0000)
         $display("FAIL reset flags: got %b expected 0000", {busy, cpu_stall, byte_ready, done});
      else n_pass++;
      n_checks++;
      if (words_loaded !== 7'd0) $display("FAIL reset words_loaded: got %0d expected 0", words_loaded);
      else n_pass++;
      for (int i = 0; i < 64; i++) begin
         a = 6'(i);
         #1;
         n_checks++;
         if (inst !== 32'h0) $display("FAIL reset inst a=%0d: got %h expected 00000000", i, inst);
         else n_pass++;
      end
      step();
   endtask

   task automatic test_two_word();
      logic [7:0] b [8];
      int idx;
      logic exp_ready, exp_busy, exp_done;
      b = '{8'h14, 8'h00, 8'h0C, 8'h22, 8'h30, 8'h00, 8'h00, 8'h45};
      idx = 0;
      a = 6'd0;
      byte_valid = 1'b1;
      byte_data = b[0];
      start_load(7'd2);
      for (int c = 1; c <= 12; c++) begin
         byte_data = (idx < 8) ? b[idx] : 8'h00;
         exp_ready = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
         exp_busy  = (c <= 11);
         exp_done  = (c == 11);
         n_checks++;
         if ({byte_ready, busy, cpu_stall, done} !== {exp_ready, exp_busy, exp_busy, exp_done})
            $display("FAIL two_word flags c=%0d: got %b expected %b", c,
                     {byte_ready, busy, cpu_stall, done}, {exp_ready, exp_busy, exp_busy, exp_done});
         else n_pass++;
         n_checks++;
         if (inst !== (exp_busy ? 32'h0 : 32'h14000C22))
            $display("FAIL two_word inst0 c=%0d: got %h expected %h", c, inst,
                     exp_busy ? 32'h0 : 32'h14000C22);
         else n_pass++;
         if (exp_ready) idx++;
         if (c < 12) step();
      end
      byte_valid = 1'b0;
      a = 6'd1;
      #1;
      n_checks++;
      if (inst !== 32'h30000045) $display("FAIL two_word inst1: got %h expected 30000045", inst);
      else n_pass++;
      a = 6'd2;
      #1;
      n_checks++;
      if (inst !== 32'h0) $display("FAIL two_word inst2: got %h expected 00000000", inst);
      else n_pass++;
      n_checks++;
      if (words_loaded !== 7'd2) $display("FAIL two_word words_loaded: got %0d expected 2", words_loaded);
      else n_pass++;
      step();
   endtask

   task automatic test_bubbles();
      logic [7:0] b [8];
      int idx;
      int done_cyc;
      logic exp_ready;
      b = '{8'h14, 8'h00, 8'h0C, 8'h22, 8'h30, 8'h00, 8'h00, 8'h45};
      idx = 0;
      done_cyc = -1;
      start_load(7'd2);
      for (int c = 1; c <= 15; c++) begin
         byte_valid = !(c >= 3 && c <= 5);
         byte_data  = (idx < 8) ? b[idx] : 8'h00;
         exp_ready  = (c >= 1 && c <= 7) || (c >= 9 && c <= 12);
         n_checks++;
         if (byte_ready !== exp_ready)
            $display("FAIL bubbles ready c=%0d: got %b expected %b", c, byte_ready, exp_ready);
         else n_pass++;
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (exp_ready && byte_valid) idx++;
         if (c < 15) step();
      end
      byte_valid = 1'b0;
      n_checks++;
      if (done_cyc != 14) $display("FAIL bubbles done cycle: got %0d expected 14", done_cyc);
      else n_pass++;
      a = 6'd0;
      #1;
      n_checks++;
      if (inst !== 32'h14000C22) $display("FAIL bubbles inst0: got %h expected 14000C22", inst);
      else n_pass++;
      a = 6'd1;
      #1;
      n_checks++;
      if (inst !== 32'h30000045) $display("FAIL bubbles inst1: got %h expected 30000045", inst);
      else n_pass++;
      step();
   endtask

   task automatic test_clamp();
      int idx;
      int ready_n, done_n, done_cyc;
      logic exp_ready;
      idx = 0;
      ready_n = 0;
      done_n = 0;
      done_cyc = -1;
      byte_valid = 1'b1;
      start_load(7'd100);
      for (int c = 1; c <= 322; c++) begin
         byte_data = 8'(idx);
         exp_ready = (c <= 320) && (c % 5 != 0);
         if (byte_ready === 1'b1) ready_n++;
         if (done === 1'b1) begin
            done_n++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 321) begin
            n_checks++;
            if (byte_ready !== 1'b0) $display("FAIL clamp 257th byte ready: got %b expected 0", byte_ready);
            else n_pass++;
         end
         if (exp_ready) idx++;
         if (c < 322) step();
      end
      byte_valid = 1'b0;
      n_checks++;
      if (ready_n != 256) $display("FAIL clamp accepted bytes: got %0d expected 256", ready_n);
      else n_pass++;
      n_checks++;
      if (done_n != 1 || done_cyc != 321)
         $display("FAIL clamp done: got %0d pulses at c=%0d expected 1 at c=321", done_n, done_cyc);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || words_loaded !== 7'd64)
         $display("FAIL clamp end: got busy=%b words=%0d expected busy=0 words=64", busy, words_loaded);
      else n_pass++;
      a = 6'd0;
      #1;
      n_checks++;
      if (inst !== 32'h00010203) $display("FAIL clamp inst0: got %h expected 00010203", inst);
      else n_pass++;
      a = 6'd63;
      #1;
      n_checks++;
      if (inst !== 32'hFCFDFEFF) $display("FAIL clamp inst63: got %h expected FCFDFEFF", inst);
      else n_pass++;
      step();
   endtask

   task automatic test_count_zero();
      byte_valid = 1'b0;
      start_load(7'd0);
      n_checks++;
      if ({done, busy, byte_ready} !== 3'b110)
         $display("FAIL zero cycle1: got done/busy/ready=%b expected 110", {done, busy, byte_ready});
      else n_pass++;
      step();
      n_checks++;
      if ({done, busy, words_loaded} !== {2'b00, 7'd0})
         $display("FAIL zero cycle2: got done=%b busy=%b words=%0d expected 0 0 0", done, busy, words_loaded);
      else n_pass++;
      a = 6'd1;
      #1;
      n_checks++;
      if (inst !== 32'h04050607) $display("FAIL zero mem kept: got %h expected 04050607", inst);
      else n_pass++;
      step();
   endtask

   task automatic test_ignored_start();
      logic [7:0] b [4];
      int idx, done_cyc;
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      idx = 0;
      done_cyc = -1;
      byte_valid = 1'b1;
      byte_data = b[0];
      start_load(7'd1);
      for (int c = 1; c <= 7; c++) begin
         byte_data  = (idx < 4) ? b[idx] : 8'h00;
         load_start = (c == 2);
         load_count = (c == 2) ? 7'd5 : 7'd0;
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (c <= 4) idx++;
         if (c < 7) step();
      end
      load_start = 1'b0;
      byte_valid = 1'b0;
      n_checks++;
      if (done_cyc != 6) $display("FAIL ignored done cycle: got %0d expected 6", done_cyc);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || words_loaded !== 7'd1)
         $display("FAIL ignored end: got busy=%b words=%0d expected busy=0 words=1", busy, words_loaded);
      else n_pass++;
      a = 6'd0;
      #1;
      n_checks++;
      if (inst !== 32'h11223344) $display("FAIL ignored inst0: got %h expected 11223344", inst);
      else n_pass++;
      a = 6'd1;
      #1;
      n_checks++;
      if (inst !== 32'h04050607) $display("FAIL ignored inst1 kept: got %h expected 04050607", inst);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b [4];
      int done_n, done_cyc, idx;
      int bad;
      byte_valid = 1'b1;
      byte_data = 8'hAA;
      start_load(7'd3);
      for (int c = 1; c <= 7; c++) begin
         byte_data = 8'(8'hA0 + c);
         step();
      end
      // Cycle 8: six bytes accepted, one word written.
      byte_valid = 1'b0;
      rst = 1'b1;
      step();
      n_checks++;
      if ({busy, cpu_stall, byte_ready, done} !== 4'b0000 || words_loaded !== 7'd0)
         $display("FAIL midrst flags: got %b words=%0d expected 0000 words=0",
                  {busy, cpu_stall, byte_ready, done}, words_loaded);
      else n_pass++;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         a = 6'(i);
         #1;
         if (inst !== 32'h0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL midrst mem cleared: got %0d nonzero entries expected 0", bad);
      else n_pass++;
      done_n = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (done === 1'b1) done_n++;
      end
      n_checks++;
      if (done_n != 0) $display("FAIL midrst no done: got %0d pulses expected 0", done_n);
      else n_pass++;

      b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      idx = 0;
      done_cyc = -1;
      byte_valid = 1'b1;
      byte_data = b[0];
      start_load(7'd1);
      for (int c = 1; c <= 7; c++) begin
         byte_data = (idx < 4) ? b[idx] : 8'h00;
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (c <= 4) idx++;
         if (c < 7) step();
      end
      byte_valid = 1'b0;
      n_checks++;
      if (done_cyc != 6) $display("FAIL reload done cycle: got %0d expected 6", done_cyc);
      else n_pass++;
      a = 6'd0;
      #1;
      n_checks++;
      if (inst !== 32'hDEADBEEF) $display("FAIL reload inst0: got %h expected DEADBEEF", inst);
      else n_pass++;
      a = 6'd1;
      #1;
      n_checks++;
      if (inst !== 32'h0) $display("FAIL reload inst1: got %h expected 00000000", inst);
      else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_bubbles();
      test_clamp();
      test_count_zero();
      test_ignored_start();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
